// File: rtl/wb_upsizer_32_128_if.sv
// Generic pipelined Wishbone bus bundle. Its address and data widths are set per instance.
// Valid/ready rule: a request transfers on a cycle where cyc & stb & ~stall holds; ack/err each return exactly one response, in order.
interface wb_upsizer_32_128_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;
    logic          stall;

    modport master (output cyc, stb, we, addr, sel, wdata,
                    input  rdata, ack, err, stall);
    modport slave  (input  cyc, stb, we, addr, sel, wdata,
                    output rdata, ack, err, stall);
endinterface

// File: rtl/wb_upsizer_32_128.sv
// Bridges a 32-bit pipelined Wishbone slave port onto a 128-bit master port.
// A tag FIFO records the lane and direction of each request, so that each returning response is routed to the right lane.
module wb_upsizer_32_128 #(
    parameter int M_AW  = 22,
    parameter int DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_upsizer_32_128_if.slave    s_bus,
    wb_upsizer_32_128_if.master   m_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       we;
        logic [1:0] lane;
    } tag_t;

    logic              req_valid_q, req_valid_d;
    logic              m_we_q, m_we_d;
    logic [M_AW-1:0]   m_addr_q, m_addr_d;
    logic [15:0]       m_sel_q, m_sel_d;
    logic [127:0]      m_wdata_q, m_wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    tag_t              tag_mem_q [DEPTH];
    tag_t              tag_mem_d [DEPTH];
    logic              s_ack_q, s_ack_d;
    logic              s_err_q, s_err_d;
    logic [31:0]       s_rdata_q, s_rdata_d;

    logic              s_stall, m_cyc, acc, take, resp, abort;
    logic [1:0]        lane;
    tag_t              tag_head;

    assign lane     = s_bus.addr[1:0];
    assign tag_head = tag_mem_q[rd_ptr_q];
    assign s_stall  = (cnt_q == CW'(DEPTH)) | (req_valid_q & m_bus.stall);
    assign acc      = s_bus.cyc & s_bus.stb & ~s_stall;
    assign take     = req_valid_q & ~m_bus.stall;
    assign m_cyc    = s_bus.cyc & (req_valid_q | (cnt_q != '0));
    assign resp     = m_cyc & (m_bus.ack | m_bus.err) & (cnt_q != '0);
    // Dropping cyc with work in flight abandons it; late memory responses then find cnt==0.
    assign abort    = ~s_bus.cyc & (cnt_q != '0);

    always_comb begin
        req_valid_d = req_valid_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_sel_d     = m_sel_q;
        m_wdata_d   = m_wdata_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_mem_d   = tag_mem_q;
        s_ack_d     = 1'b0;
        s_err_d     = 1'b0;
        s_rdata_d   = '0;
        cnt_d       = cnt_q + CW'(acc) - CW'(resp);

        if (acc) begin
            req_valid_d         = 1'b1;
            m_we_d              = s_bus.we;
            m_addr_d            = s_bus.addr[M_AW+1:2];
            m_sel_d             = 16'(s_bus.sel) << {lane, 2'b00};
            m_wdata_d           = {4{s_bus.wdata}};
            tag_mem_d[wr_ptr_q] = '{we: s_bus.we, lane: lane};
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end else if (take) begin
            req_valid_d = 1'b0;
        end

        if (resp) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            s_ack_d  = m_bus.ack;
            s_err_d  = m_bus.err;
            if (m_bus.ack & ~m_bus.err & ~tag_head.we)
                s_rdata_d = m_bus.rdata[{tag_head.lane, 5'b00000} +: 32];
        end

        if (abort) begin
            req_valid_d = 1'b0;
            cnt_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_sel_q     <= '0;
            m_wdata_q   <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s_ack_q     <= 1'b0;
            s_err_q     <= 1'b0;
            s_rdata_q   <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_sel_q     <= m_sel_d;
            m_wdata_q   <= m_wdata_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            s_ack_q     <= s_ack_d;
            s_err_q     <= s_err_d;
            s_rdata_q   <= s_rdata_d;
        end
    end

    // Tag storage needs no reset: valid entries are those between the reset pointers.
    always_ff @(posedge clk_i) begin
        tag_mem_q <= tag_mem_d;
    end

    assign s_bus.rdata = s_rdata_q;
    assign s_bus.ack   = s_ack_q;
    assign s_bus.err   = s_err_q;
    assign s_bus.stall = s_stall;
    assign m_bus.cyc   = m_cyc;
    assign m_bus.stb   = req_valid_q;
    assign m_bus.we    = m_we_q;
    assign m_bus.addr  = m_addr_q;
    assign m_bus.sel   = m_sel_q;
    assign m_bus.wdata = m_wdata_q;
endmodule

// File: tb/tb_wb_upsizer_32_128.sv
// Directed bench for wb_upsizer_32_128: lane mapping, ordering, full stall, master stall, abort and reset.
module tb_wb_upsizer_32_128;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_xfer = 0;
    int   xb;

    localparam logic [127:0] RWORD = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;

    wb_upsizer_32_128_if #(.AW(24), .DW(32))  s_bus ();
    wb_upsizer_32_128_if #(.AW(22), .DW(128)) m_bus ();

    wb_upsizer_32_128 #(.M_AW(22), .DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .s_bus (s_bus.slave),
        .m_bus (m_bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && m_bus.stb && !m_bus.stall) n_xfer <= n_xfer + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rd_word(input int j);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[32*k +: 32] = {8'(j), 8'(k), 16'h5A5A};
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        s_bus.cyc = 0; s_bus.stb = 0; s_bus.we = 0; s_bus.addr = '0; s_bus.sel = '0; s_bus.wdata = '0;
        m_bus.rdata = '0; m_bus.ack = 0; m_bus.err = 0; m_bus.stall = 0;
        tick(); tick();
        chk("rst_ctrl", {s_bus.ack, s_bus.err, s_bus.stall, m_bus.stb, m_bus.cyc, m_bus.we}, '0);
        chk("rst_rdata", s_bus.rdata, '0);
        chk("rst_maddr", m_bus.addr, '0);
        chk("rst_msel", m_bus.sel, '0);
        chk("rst_mwdata", m_bus.wdata, '0);
        rst = 1'b0;
        tick();

        // single read, lane 2
        s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 0; s_bus.addr = 24'h6; s_bus.sel = 4'hF;
        #1 chk("t1_stall", s_bus.stall, 0);
        tick();
        s_bus.stb = 0;
        #1;
        chk("t1_mstb", m_bus.stb, 1);
        chk("t1_maddr", m_bus.addr, 22'h1);
        chk("t1_msel", m_bus.sel, 16'h0F00);
        chk("t1_mwe", m_bus.we, 0);
        chk("t1_mcyc", m_bus.cyc, 1);
        tick();
        m_bus.ack = 1; m_bus.rdata = RWORD;
        tick();
        m_bus.ack = 0;
        chk("t1_ack", s_bus.ack, 1);
        chk("t1_rdata", s_bus.rdata, 32'h22221111);
        chk("t1_err", s_bus.err, 0);
        tick();
        chk("t1_ack_clr", s_bus.ack, 0);
        chk("t1_mcyc_idle", m_bus.cyc, 0);

        // write, lane 3
        s_bus.stb = 1; s_bus.we = 1; s_bus.addr = 24'h3; s_bus.sel = 4'h5; s_bus.wdata = 32'hCAFEBABE;
        tick();
        s_bus.stb = 0; s_bus.we = 0;
        #1;
        chk("t2_msel", m_bus.sel, 16'h5000);
        chk("t2_mwdata", m_bus.wdata, {4{32'hCAFEBABE}});
        chk("t2_mwe", m_bus.we, 1);
        tick();
        m_bus.ack = 1; m_bus.rdata = '1;
        tick();
        m_bus.ack = 0;
        chk("t2_ack", s_bus.ack, 1);
        chk("t2_rdata", s_bus.rdata, 32'h0);

        // 16 back-to-back reads until full
        xb = n_xfer;
        s_bus.stb = 1; s_bus.we = 0; s_bus.sel = 4'hF;
        for (int i = 0; i < 16; i++) begin
            s_bus.addr = 24'((i << 2) | (i & 3));
            #1;
            if (i == 0 || i == 15) chk("t3_stall_early", s_bus.stall, 0);
            tick();
        end
        s_bus.stb = 0;
        #1 chk("t3_full", s_bus.stall, 1);
        tick();
        chk("t3_xfers", n_xfer - xb, 16);
        for (int j = 0; j < 16; j++) begin
            m_bus.ack = 1; m_bus.rdata = rd_word(j);
            #1;
            if (j == 0) chk("t3_stall_resp", s_bus.stall, 1);
            tick();
            chk("t3_ack", s_bus.ack, 1);
            chk("t3_rdata", s_bus.rdata, {8'(j), 8'(j & 3), 16'h5A5A});
            if (j == 0) chk("t3_stall_free", s_bus.stall, 0);
        end
        m_bus.ack = 0;
        tick();
        chk("t3_ack_clr", s_bus.ack, 0);
        chk("t3_mcyc_idle", m_bus.cyc, 0);

        // master stall for 5 cycles
        xb = n_xfer;
        m_bus.stall = 1; s_bus.stb = 1; s_bus.addr = 24'h25;
        #1 chk("t4_accept", s_bus.stall, 0);
        tick();
        s_bus.addr = 24'h30;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_sstall", s_bus.stall, 1);
            chk("t4_mstb", m_bus.stb, 1);
            chk("t4_maddr", m_bus.addr, 22'h9);
            chk("t4_msel", m_bus.sel, 16'h00F0);
            tick();
        end
        m_bus.stall = 0;
        #1 chk("t4_release", s_bus.stall, 0);
        tick();
        s_bus.stb = 0;
        #1;
        chk("t4_maddr2", m_bus.addr, 22'hC);
        chk("t4_msel2", m_bus.sel, 16'h000F);
        chk("t4_mstb2", m_bus.stb, 1);
        tick();
        chk("t4_xfers", n_xfer - xb, 2);
        m_bus.ack = 1; m_bus.rdata = RWORD;
        tick();
        chk("t4_rdata0", s_bus.rdata, 32'hDDDDCCCC);
        tick();
        m_bus.ack = 0;
        chk("t4_rdata1", s_bus.rdata, 32'hBBBBAAAA);
        tick();

        // abort with 3 outstanding
        s_bus.stb = 1;
        for (int i = 0; i < 3; i++) begin
            s_bus.addr = 24'(i);
            tick();
        end
        s_bus.stb = 0;
        tick();
        s_bus.cyc = 0;
        #1 chk("t5_mcyc_drop", m_bus.cyc, 0);
        tick();
        s_bus.cyc = 1; m_bus.ack = 1; m_bus.rdata = RWORD;
        #1;
        chk("t5_mcyc_after", m_bus.cyc, 0);
        chk("t5_stall", s_bus.stall, 0);
        tick();
        m_bus.ack = 0;
        chk("t5_no_ack", s_bus.ack, 0);

        // reset with 4 outstanding and a pending request
        s_bus.stb = 1;
        for (int i = 0; i < 4; i++) begin
            s_bus.addr = 24'(i);
            tick();
        end
        s_bus.stb = 0;
        #1 chk("t6_pending", m_bus.stb, 1);
        rst = 1;
        tick();
        chk("t6_ctrl", {s_bus.ack, s_bus.err, s_bus.stall, m_bus.stb, m_bus.cyc, m_bus.we}, '0);
        chk("t6_maddr", m_bus.addr, '0);
        chk("t6_msel", m_bus.sel, '0);
        chk("t6_mwdata", m_bus.wdata, '0);
        chk("t6_rdata", s_bus.rdata, '0);
        rst = 0; m_bus.err = 1;
        #1 chk("t6_mcyc", m_bus.cyc, 0);
        tick();
        m_bus.err = 0;
        chk("t6_no_err", s_bus.err, 0);
        chk("t6_no_ack", s_bus.ack, 0);
        s_bus.cyc = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
